id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 136 +++++++++++++
 tb/tb_id_ex_stage.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection,
// write-back bypass into the captured operands, and a saturating stall counter.
//
// Ports:
//   clock, reset           rising-edge clock; synchronous active-high reset
//   flush                  kills the instruction in ID (inserts a bubble)
//   id_*                   decoded instruction fields and main-control bits from ID
//   wb_RegWrite/rd/data    write-back port, bypassed into rs1/rs2 data on load
//   ex_*                   registered copy of the id_* fields (ex_valid <- id_valid)
//   stall                  combinational load-use stall to PC and IF/ID
//   stall_count            saturating count of stalled cycles
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [2:0]       id_funct3,
  input  logic [6:0]       id_funct7,
  input  logic [1:0]       id_ALUOp,
  input  logic             id_ALUSrc,
  input  logic             id_MemRead,
  input  logic             id_MemWrite,
  input  logic             id_RegWrite,
  input  logic             id_MemtoReg,
  input  logic             id_Branch,
  input  logic             wb_RegWrite,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [2:0]       ex_funct3,
  output logic [6:0]       ex_funct7,
  output logic [1:0]       ex_ALUOp,
  output logic             ex_ALUSrc,
  output logic             ex_MemRead,
  output logic             ex_MemWrite,
  output logic             ex_RegWrite,
  output logic             ex_MemtoReg,
  output logic             ex_Branch,
  output logic             stall,
  output logic [CNT_W-1:0] stall_count
);

  logic use_rs2;
  logic hazard;
  logic fwd_rs1;
  logic fwd_rs2;

  // rs2 is a real source for R-type (register operand) and for stores.
  assign use_rs2 = ~id_ALUSrc | id_MemWrite;

  assign hazard = id_valid & ex_valid & ex_MemRead & (ex_rd != 5'd0) &
                  ((ex_rd == id_rs1) | (use_rs2 & (ex_rd == id_rs2)));

  // Flush discards the ID instruction, so holding it would be pointless.
  assign stall = hazard & ~flush & ~reset;

  assign fwd_rs1 = wb_RegWrite & (wb_rd != 5'd0) & (wb_rd == id_rs1);
  assign fwd_rs2 = wb_RegWrite & (wb_rd != 5'd0) & (wb_rd == id_rs2);

  always_ff @(posedge clock) begin
    if (reset) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_funct3   <= '0;
      ex_funct7   <= '0;
      ex_ALUOp    <= 2'b00;
      ex_ALUSrc   <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_MemWrite <= 1'b0;
      ex_RegWrite <= 1'b0;
      ex_MemtoReg <= 1'b0;
      ex_Branch   <= 1'b0;
    end else if (flush | hazard) begin
      // Bubble: kill control only; data and index fields hold.
      ex_valid    <= 1'b0;
      ex_ALUOp    <= 2'b00;
      ex_ALUSrc   <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_MemWrite <= 1'b0;
      ex_RegWrite <= 1'b0;
      ex_MemtoReg <= 1'b0;
      ex_Branch   <= 1'b0;
    end else begin
      ex_valid    <= id_valid;
      ex_pc       <= id_pc;
      ex_rs1_data <= fwd_rs1 ? wb_data : id_rs1_data;
      ex_rs2_data <= fwd_rs2 ? wb_data : id_rs2_data;
      ex_imm      <= id_imm;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_funct3   <= id_funct3;
      ex_funct7   <= id_funct7;
      // An empty ID slot loads bubble control values.
      ex_ALUOp    <= id_valid ? id_ALUOp : 2'b00;
      ex_ALUSrc   <= id_valid & id_ALUSrc;
      ex_MemRead  <= id_valid & id_MemRead;
      ex_MemWrite <= id_valid & id_MemWrite;
      ex_RegWrite <= id_valid & id_RegWrite & (id_rd != 5'd0);
      ex_MemtoReg <= id_valid & id_MemtoReg;
      ex_Branch   <= id_valid & id_Branch;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [1:0]  aluop;
    logic        alusrc, memrd, memwr, regwr, memtoreg, branch;
  } ex_t;

  typedef struct packed {
    ex_t         ex;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset, flush, id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm, wb_data;
  logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
  logic [2:0]  id_funct3;
  logic [6:0]  id_funct7;
  logic [1:0]  id_ALUOp;
  logic        id_ALUSrc, id_MemRead, id_MemWrite, id_RegWrite, id_MemtoReg, id_Branch;
  logic        wb_RegWrite;

  logic        ex_valid, ex_ALUSrc, ex_MemRead, ex_MemWrite, ex_RegWrite, ex_MemtoReg, ex_Branch;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  ex_funct3;
  logic [6:0]  ex_funct7;
  logic [1:0]  ex_ALUOp;
  logic        stall;
  logic [15:0] stall_count;

  logic        v4, alusrc4, memrd4, memwr4, regwr4, memtoreg4, branch4, stall4;
  logic [31:0] pc4, rs1d4, rs2d4, imm4;
  logic [4:0]  rs14, rs24, rd4;
  logic [2:0]  f34;
  logic [6:0]  f74;
  logic [1:0]  aluop4;
  logic [3:0]  sc4;

  ex_t got;
  assign got = {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
                ex_funct3, ex_funct7, ex_ALUOp, ex_ALUSrc, ex_MemRead, ex_MemWrite,
                ex_RegWrite, ex_MemtoReg, ex_Branch};

  id_ex_stage #(.XLEN(32), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_funct3(id_funct3), .id_funct7(id_funct7), .id_ALUOp(id_ALUOp),
    .id_ALUSrc(id_ALUSrc), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
    .id_RegWrite(id_RegWrite), .id_MemtoReg(id_MemtoReg), .id_Branch(id_Branch),
    .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_funct3(ex_funct3), .ex_funct7(ex_funct7), .ex_ALUOp(ex_ALUOp),
    .ex_ALUSrc(ex_ALUSrc), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
    .ex_RegWrite(ex_RegWrite), .ex_MemtoReg(ex_MemtoReg), .ex_Branch(ex_Branch),
    .stall(stall), .stall_count(stall_count)
  );

  id_ex_stage #(.XLEN(32), .CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_funct3(id_funct3), .id_funct7(id_funct7), .id_ALUOp(id_ALUOp),
    .id_ALUSrc(id_ALUSrc), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
    .id_RegWrite(id_RegWrite), .id_MemtoReg(id_MemtoReg), .id_Branch(id_Branch),
    .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(v4), .ex_pc(pc4), .ex_rs1_data(rs1d4), .ex_rs2_data(rs2d4),
    .ex_imm(imm4), .ex_rs1(rs14), .ex_rs2(rs24), .ex_rd(rd4),
    .ex_funct3(f34), .ex_funct7(f74), .ex_ALUOp(aluop4),
    .ex_ALUSrc(alusrc4), .ex_MemRead(memrd4), .ex_MemWrite(memwr4),
    .ex_RegWrite(regwr4), .ex_MemtoReg(memtoreg4), .ex_Branch(branch4),
    .stall(stall4), .stall_count(sc4)
  );

  always #5 clock = ~clock;

  int unsigned tests = 0;
  int unsigned fails = 0;
  exp_t        sb[$];
  ex_t         m;
  int unsigned mcnt, mcnt4;

  // Reference model of the register, written from the behavioural description.
  function automatic logic model_hazard();
    logic src2;
    src2 = !id_ALUSrc || id_MemWrite;
    return id_valid && m.valid && m.memrd && (m.rd != 0) &&
           ((m.rd == id_rs1) || (src2 && (m.rd == id_rs2)));
  endfunction

  function automatic void model_edge(input logic hz);
    if (reset) begin
      m = '0; mcnt = 0; mcnt4 = 0;
    end else if (flush || hz) begin
      if (!flush) begin
        if (mcnt < 65535) mcnt++;
        if (mcnt4 < 15) mcnt4++;
      end
      m.valid = 0; m.aluop = 0;
      {m.alusrc, m.memrd, m.memwr, m.regwr, m.memtoreg, m.branch} = '0;
    end else begin
      m.valid = id_valid; m.pc = id_pc; m.imm = id_imm;
      m.rs1d = (wb_RegWrite && wb_rd != 0 && wb_rd == id_rs1) ? wb_data : id_rs1_data;
      m.rs2d = (wb_RegWrite && wb_rd != 0 && wb_rd == id_rs2) ? wb_data : id_rs2_data;
      m.rs1 = id_rs1; m.rs2 = id_rs2; m.rd = id_rd; m.f3 = id_funct3; m.f7 = id_funct7;
      if (id_valid) begin
        m.aluop = id_ALUOp; m.alusrc = id_ALUSrc; m.memrd = id_MemRead; m.memwr = id_MemWrite;
        m.regwr = id_RegWrite && (id_rd != 0); m.memtoreg = id_MemtoReg; m.branch = id_Branch;
      end else begin
        m.aluop = 0;
        {m.alusrc, m.memrd, m.memwr, m.regwr, m.memtoreg, m.branch} = '0;
      end
    end
  endfunction

  // Called just after a negedge with inputs already driven; returns at the next negedge.
  task automatic tick();
    logic hz, es;
    exp_t e, p;
    #1;
    hz = model_hazard();
    es = hz && !flush && !reset;
    tests++;
    if (stall !== es) begin
      fails++; $display("FAIL stall_comb: got %b expected %b", stall, es);
    end
    model_edge(hz);
    e.ex = m; e.cnt = mcnt[15:0]; e.cnt4 = mcnt4[3:0];
    sb.push_back(e);
    @(posedge clock); #1;
    p = sb.pop_front();
    tests++;
    if (got !== p.ex) begin
      fails++; $display("FAIL ex_regs: got %h expected %h", got, p.ex);
    end
    tests++;
    if ({stall_count, sc4} !== {p.cnt, p.cnt4}) begin
      fails++; $display("FAIL stall_count: got %0d/%0d expected %0d/%0d", stall_count, sc4, p.cnt, p.cnt4);
    end
    @(negedge clock);
  endtask

  task automatic drive_id(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [4:0] rd, input logic alusrc, input logic memrd,
                          input logic memwr, input logic regwr);
    id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    id_ALUSrc = alusrc; id_MemRead = memrd; id_MemWrite = memwr; id_RegWrite = regwr;
    id_MemtoReg = memrd; id_Branch = 1'b0;
    id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
    id_funct3 = 3'($urandom); id_funct7 = 7'($urandom); id_ALUOp = 2'($urandom);
  endtask

  task automatic drive_lw5(); drive_id(1, 5'd1, 5'd2, 5'd5, 1, 1, 0, 1); endtask
  task automatic drive_add5(); drive_id(1, 5'd5, 5'd6, 5'd7, 0, 0, 0, 1); endtask

  task automatic test_reset();
    reset = 1; drive_lw5(); tick();
    tests++;
    if (got !== '0 || stall_count !== 16'd0) begin
      fails++; $display("FAIL reset_state: got %h/%0d expected 0/0", got, stall_count);
    end
    reset = 0;
  endtask

  task automatic test_load_use();
    drive_lw5(); tick();
    drive_add5(); #1;
    tests++;
    if (stall !== 1'b1) begin fails++; $display("FAIL load_use_stall: got %b expected 1", stall); end
    tick();
    tests++;
    if (ex_valid !== 1'b0 || ex_MemRead !== 1'b0 || stall_count !== 16'd1) begin
      fails++; $display("FAIL load_use_bubble: got v=%b mr=%b cnt=%0d expected 0 0 1", ex_valid, ex_MemRead, stall_count);
    end
    tick();
    tests++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd7 || ex_rs1 !== 5'd5) begin
      fails++; $display("FAIL load_use_release: got v=%b rd=%0d rs1=%0d expected 1 7 5", ex_valid, ex_rd, ex_rs1);
    end
  endtask

  task automatic test_flush_hazard();
    drive_lw5(); tick();
    drive_add5(); flush = 1; #1;
    tests++;
    if (stall !== 1'b0) begin fails++; $display("FAIL flush_stall: got %b expected 0", stall); end
    tick();
    tests++;
    if (ex_valid !== 1'b0 || ex_RegWrite !== 1'b0 || stall_count !== 16'd1) begin
      fails++; $display("FAIL flush_bubble: got v=%b rw=%b cnt=%0d expected 0 0 1", ex_valid, ex_RegWrite, stall_count);
    end
    flush = 0;
  endtask

  task automatic test_bypass();
    wb_RegWrite = 1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
    drive_id(1, 5'd4, 5'd3, 5'd8, 0, 0, 0, 1); id_rs2_data = 32'h0;
    tick();
    tests++;
    if (ex_rs2_data !== 32'hDEADBEEF) begin
      fails++; $display("FAIL bypass_rs2: got %h expected deadbeef", ex_rs2_data);
    end
    wb_rd = 5'd0; drive_id(1, 5'd0, 5'd0, 5'd8, 0, 0, 0, 1); id_rs1_data = 32'h1234;
    tick();
    tests++;
    if (ex_rs1_data !== 32'h1234) begin
      fails++; $display("FAIL bypass_x0: got %h expected 00001234", ex_rs1_data);
    end
    wb_RegWrite = 0;
  endtask

  task automatic test_x0();
    drive_id(1, 5'd1, 5'd2, 5'd0, 0, 0, 0, 1); tick();
    tests++;
    if (ex_RegWrite !== 1'b0) begin fails++; $display("FAIL x0_regwrite: got %b expected 0", ex_RegWrite); end
    drive_id(1, 5'd1, 5'd2, 5'd0, 1, 1, 0, 1); tick();
    drive_id(1, 5'd0, 5'd0, 5'd9, 0, 0, 0, 1); #1;
    tests++;
    if (stall !== 1'b0) begin fails++; $display("FAIL x0_hazard: got %b expected 0", stall); end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      drive_id($urandom_range(7, 0) != 0, 5'($urandom_range(3, 0)), 5'($urandom_range(3, 0)),
               5'($urandom_range(3, 0)), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      id_Branch = 1'($urandom);
      flush = ($urandom_range(7, 0) == 0);
      wb_RegWrite = 1'($urandom); wb_rd = 5'($urandom_range(3, 0)); wb_data = $urandom;
      tick();
    end
    flush = 0; wb_RegWrite = 0;
  endtask

  task automatic test_saturation();
    reset = 1; tick(); reset = 0;
    for (int i = 0; i < 20; i++) begin
      drive_lw5(); tick();
      drive_add5(); tick();
    end
    tests++;
    if (sc4 !== 4'hF || stall_count !== 16'd20) begin
      fails++; $display("FAIL saturation: got %h/%0d expected f/20", sc4, stall_count);
    end
  endtask

  task automatic test_reset_mid_stall();
    drive_lw5(); tick();
    drive_add5(); #1;
    tests++;
    if (stall !== 1'b1) begin fails++; $display("FAIL pre_reset_stall: got %b expected 1", stall); end
    reset = 1; #1;
    tests++;
    if (stall !== 1'b0) begin fails++; $display("FAIL reset_forces_stall: got %b expected 0", stall); end
    tick();
    tests++;
    if (got !== '0 || stall_count !== 16'd0 || sc4 !== 4'd0 || stall !== 1'b0) begin
      fails++; $display("FAIL reset_mid_stall: got %h/%0d/%0d stall=%b expected 0", got, stall_count, sc4, stall);
    end
    tick();
    reset = 0;
  endtask

  initial begin
    m = '0; mcnt = 0; mcnt4 = 0;
    reset = 1; flush = 0; wb_RegWrite = 0; wb_rd = 0; wb_data = 0;
    drive_id(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    test_reset();
    test_load_use();
    test_flush_hazard();
    test_bypass();
    test_x0();
    test_back_to_back();
    test_saturation();
    test_reset_mid_stall();
    if (sb.size() != 0) begin
      fails++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
